// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer for the 5-stage MIPS core: drives the PC and pipeline
// register enables/flushes. It handles load-use stalls, taken-branch flushes
// and multi-cycle data-memory accesses. It also flags a memory timeout and
// counts stall cycles for performance debug.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// ST_RUN      | normal flow; load-use / branch / memory-miss checks
// ST_MEM_WAIT | EX/MEM access outstanding, pipeline frozen, wait_cnt runs
// ST_FAULT    | memory never answered; frozen until reset, mem_err set
module pipe_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset_in,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             idex_memread,
    input  logic [4:0]       idex_rd,
    input  logic             ex_branch_taken,
    input  logic [1:0]       exmem_m,
    input  logic             dmem_ready,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             memwb_flush,
    output logic             dmem_req,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_FAULT    = 2'd2
    } state_t;

    // Last wait_cnt value before the timeout fires.
    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    state_t           state_q, state_d;
    logic [7:0]       wait_cnt_q, wait_cnt_d;
    logic             mem_err_q, mem_err_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic mem_access;
    logic load_use;
    logic dmem_req_raw;

    assign mem_access = (exmem_m != 2'b00);
    // Register 0 is hardwired to zero, so it never creates a hazard.
    assign load_use   = idex_memread && (idex_rd != 5'd0) &&
                        ((idex_rd == id_rs) || (id_uses_rt && (idex_rd == id_rt)));

    // State, wait counter, error flag and stall counter registers.
    always_ff @(posedge clk or negedge reset_in) begin
        if (!reset_in) begin
            state_q     <= ST_RUN;
            wait_cnt_q  <= '0;
            mem_err_q   <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            mem_err_q   <= mem_err_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Next-state and wait-counter logic.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        case (state_q)
            ST_RUN: begin
                if (mem_access && !dmem_ready) begin
                    state_d    = ST_MEM_WAIT;
                    wait_cnt_d = '0;
                end
            end
            ST_MEM_WAIT: begin
                wait_cnt_d = wait_cnt_q + 8'd1;
                if (dmem_ready) begin
                    state_d = ST_RUN;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    state_d = ST_FAULT;
                end
            end
            ST_FAULT: begin
                state_d = ST_FAULT;
            end
            default: begin
                state_d    = ST_RUN;
                wait_cnt_d = '0;
            end
        endcase
    end

    // Pipeline control outputs from state and current inputs.
    always_comb begin
        pc_en        = 1'b1;
        ifid_en      = 1'b1;
        idex_en      = 1'b1;
        exmem_en     = 1'b1;
        ifid_flush   = 1'b0;
        idex_flush   = 1'b0;
        memwb_flush  = 1'b0;
        dmem_req_raw = mem_access;
        case (state_q)
            ST_FAULT: begin
                pc_en        = 1'b0;
                ifid_en      = 1'b0;
                idex_en      = 1'b0;
                exmem_en     = 1'b0;
                memwb_flush  = 1'b1;
                dmem_req_raw = 1'b0;
            end
            default: begin
                // In MEM_WAIT the request stays up even if the M field changed.
                if (state_q == ST_MEM_WAIT) begin
                    dmem_req_raw = 1'b1;
                end
                if (!dmem_ready && (state_q == ST_MEM_WAIT || mem_access)) begin
                    // Frozen: branch and load-use are deferred to the release cycle.
                    pc_en       = 1'b0;
                    ifid_en     = 1'b0;
                    idex_en     = 1'b0;
                    exmem_en    = 1'b0;
                    memwb_flush = 1'b1;
                end else if (ex_branch_taken) begin
                    ifid_flush = 1'b1;
                    idex_flush = 1'b1;
                end else if (load_use) begin
                    pc_en      = 1'b0;
                    ifid_en    = 1'b0;
                    idex_flush = 1'b1;
                end
            end
        endcase
    end

    // Error flag is sticky; stall counter saturates at all-ones.
    always_comb begin
        mem_err_d   = mem_err_q || (state_d == ST_FAULT);
        stall_cnt_d = stall_cnt_q;
        if (!pc_en && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    // A request must not linger while reset is held, whatever exmem_m shows.
    assign dmem_req  = dmem_req_raw && reset_in;
    assign mem_err   = mem_err_q;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Pipeline sequencer for the 5-stage 32-bit MIPS core. It drives the enable and flush controls of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers. It resolves load-use hazards, taken-branch flushes and multi-cycle data-memory accesses, and holds the pipeline frozen while the EX/MEM stage waits on memory. It also flags a memory timeout and counts stall cycles for performance debug.

## Interface
Parameters:
- MEM_TIMEOUT, 64: maximum number of MEM_WAIT cycles before the fault state; legal range 2..255.
- CNT_W, 16: width of the stall counter.

Ports:
- clk  in  1  rising-edge clock.
- reset_in  in  1  asynchronous, active-low reset.
- id_rs  in  5  rs field of the instruction in ID.
- id_rt  in  5  rt field of the instruction in ID.
- id_uses_rt  in  1  the ID instruction reads rt.
- idex_memread  in  1  the ID/EX instruction is a load.
- idex_rd  in  5  destination register of the ID/EX instruction.
- ex_branch_taken  in  1  a branch resolved taken in EX this cycle.
- exmem_m  in  2  EX/MEM M field: bit1 MemRead, bit0 MemWrite.
- dmem_ready  in  1  data memory completes the current access this cycle.
- pc_en, ifid_en, idex_en, exmem_en  out  1 each  register load enables.
- ifid_flush, idex_flush, memwb_flush  out  1 each  synchronous bubble insertion into the named register.
- dmem_req  out  1  data-memory access request.
- mem_err  out  1  sticky timeout flag.
- stall_cnt  out  CNT_W  saturating count of cycles with pc_en=0.

## Operation
- Control outputs (enables, flushes, dmem_req) are combinational from the state and the current inputs. mem_err, stall_cnt and the wait counter are registered.
- Definitions:
  - mem_access = exmem_m != 0.
  - load_use = idex_memread & (idex_rd != 0) & ((idex_rd == id_rs) | (id_uses_rt & (idex_rd == id_rt))).
- Default outputs: all enables 1, all flushes 0, dmem_req = mem_access.
- State RUN, evaluated in priority order:
  1. mem_access & !dmem_ready:
     - pc_en, ifid_en, idex_en, exmem_en = 0.
     - memwb_flush = 1.
     - Go to MEM_WAIT and clear wait_cnt.
     - The branch and load-use checks are ignored this cycle.
  2. ex_branch_taken:
     - ifid_flush = 1 and idex_flush = 1.
     - pc_en = 1 so the PC loads the branch target.
     - Stay in RUN.
  3. load_use:
     - pc_en = 0, ifid_en = 0, idex_flush = 1.
     - Stay in RUN. A single bubble is sufficient because the load advances.
- State MEM_WAIT:
  - dmem_req = 1. Pipeline frozen as in RUN rule 1.
  - wait_cnt increments each cycle.
  - When dmem_ready = 1:
    - exmem_en = 1 and memwb_flush = 0.
    - The branch and load-use rules from RUN apply this same cycle.
    - Next state is RUN.
  - When wait_cnt == MEM_TIMEOUT-1 and dmem_ready = 0: go to FAULT.
- State FAULT:
  - All enables 0, memwb_flush = 1, dmem_req = 0.
  - mem_err = 1.
  - Exit only through reset.
- stall_cnt increments on every cycle with pc_en = 0 and saturates at all-ones.
- Encoding and width rules:
  - wait_cnt is 8 bits.
  - A register number of 0 never creates a hazard.
  - A branch held in EX during MEM_WAIT is acted on in the release cycle.

## Timing
- Reset (asynchronous assert, synchronous release): state = RUN, wait_cnt = 0, stall_cnt = 0, mem_err = 0. Output values then follow the RUN rules for the current inputs.
- Load-use costs exactly 1 stall cycle. A taken branch costs 2 flushed slots.
- A memory access with dmem_ready low for N cycles (N < MEM_TIMEOUT) costs N frozen cycles. The access completes in the cycle dmem_ready rises.
- dmem_ready high in the first RUN cycle of an access means zero stall.
- FAULT is entered on the edge after the MEM_TIMEOUT-th consecutive not-ready cycle in MEM_WAIT. mem_err reads 1 from that edge onward.
- Reset asserted mid-MEM_WAIT clears every register immediately. A pending dmem_req drops within the same cycle.

## Test plan
- Load-use: idex_memread=1, idex_rd=8, id_rs=8 for one cycle -> pc_en=0, ifid_en=0, idex_flush=1; stall_cnt goes 0->1. The same stimulus with idex_rd=0 -> no stall.
- Branch plus load-use together: ex_branch_taken=1 and load_use=1 -> ifid_flush=1, idex_flush=1, pc_en=1; stall_cnt unchanged.
- Memory wait: exmem_m=2'b10 with dmem_ready low for 3 cycles, then high -> 3 frozen cycles with memwb_flush=1 and dmem_req=1. The 4th cycle has exmem_en=1. stall_cnt=3, state back to RUN.
- Timeout with MEM_TIMEOUT=4: exmem_m=2'b01, dmem_ready held 0 -> FAULT after 4 MEM_WAIT cycles. mem_err=1, dmem_req=0, and both persist with dmem_ready later high.
- Async reset: assert reset_in=0 in the 2nd MEM_WAIT cycle, between clock edges -> mem_err=0, stall_cnt=0, state RUN without waiting for a clock edge.
- Saturation with CNT_W=4: hold load_use active for 20 cycles -> stall_cnt stops at 15.
